// File: rtl/pokey_bus_pkg.sv
// Shared types and constants for the POKEY bus master: FSM states,
// chip-select encodings and the POKEY register map.
package pokey_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [1:0] CS_SEL  = 2'b10;
  localparam logic [1:0] CS_IDLE = 2'b01;

  // Write-side register map
  localparam logic [3:0] AUDF1  = 4'h0;
  localparam logic [3:0] AUDC1  = 4'h1;
  localparam logic [3:0] AUDF2  = 4'h2;
  localparam logic [3:0] AUDC2  = 4'h3;
  localparam logic [3:0] AUDF3  = 4'h4;
  localparam logic [3:0] AUDC3  = 4'h5;
  localparam logic [3:0] AUDF4  = 4'h6;
  localparam logic [3:0] AUDC4  = 4'h7;
  localparam logic [3:0] AUDCTL = 4'h8;
  localparam logic [3:0] STIMER = 4'h9;
  localparam logic [3:0] SKREST = 4'hA;
  localparam logic [3:0] POTGO  = 4'hB;
  localparam logic [3:0] SEROUT = 4'hD;
  localparam logic [3:0] IRQEN  = 4'hE;
  localparam logic [3:0] SKCTL  = 4'hF;

  // Read-side register map
  localparam logic [3:0] KBCODE = 4'h9;
  localparam logic [3:0] RANDOM = 4'hA;
  localparam logic [3:0] SERIN  = 4'hD;
  localparam logic [3:0] IRQST  = 4'hE;
  localparam logic [3:0] SKSTAT = 4'hF;

  function automatic int unsigned ph_width(input int unsigned half);
    return $clog2(2 * half);
  endfunction

endpackage

// File: rtl/pokey_phase_gen.sv
// Free-running phi2 phase counter: ph walks 0..2*HALF-1, phi2 is high
// for the upper half of the period.
module pokey_phase_gen
  import pokey_bus_pkg::*;
#(
  parameter int unsigned HALF = 4,
  parameter int unsigned PW   = ph_width(HALF)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [PW-1:0] ph,
  output logic          phi2,
  output logic          start,
  output logic          last
);

  localparam logic [PW-1:0] PH_LAST = PW'(2 * HALF - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(HALF);

  logic [PW-1:0] ph_next;

  always_comb begin
    ph_next = (ph == PH_LAST) ? '0 : ph + 1'b1;
  end

  // phi2 is computed from ph_next so the registered value lines up with ph
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph   <= '0;
      phi2 <= 1'b0;
    end else begin
      ph   <= ph_next;
      phi2 <= (ph_next >= PH_HIGH);
    end
  end

  assign start = (ph == '0);
  assign last  = (ph == PH_LAST);

endmodule

// File: rtl/pokey_bus_master.sv
// Host-request to POKEY bus-cycle bridge: one request per phi2 period,
// aligned to the phase counter, plus a 2-flop irq synchronizer.
module pokey_bus_master
  import pokey_bus_pkg::*;
#(
  parameter int unsigned HALF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic       rsp_rw,
  output logic [7:0] rsp_rdata,
  output logic       phi2,
  output logic [1:0] cs,
  output logic       rw,
  output logic [3:0] a,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in,
  input  logic       irq_n,
  output logic       irq
);

  localparam int unsigned    PW          = ph_width(HALF);
  localparam logic [PW-1:0]  PH_PRE_HIGH = PW'(HALF - 1);

  logic [PW-1:0] ph;
  logic          start;
  logic          last;
  state_t        state;
  logic          rw_q;
  logic [3:0]    addr_q;
  logic [7:0]    wdata_q;
  logic          irq_s1;
  logic          irq_s2;

  pokey_phase_gen #(
    .HALF (HALF),
    .PW   (PW)
  ) u_phase (
    .clk   (clk),
    .rst   (reset),
    .ph    (ph),
    .phi2  (phi2),
    .start (start),
    .last  (last)
  );

  assign req_ready = (state == IDLE);

  // Bus outputs are loaded one edge early so they are valid for the whole
  // ph==0..2*HALF-1 window; acceptance at the last phase skips WAIT entirely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rw_q      <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      cs        <= CS_IDLE;
      rw        <= 1'b1;
      a         <= '0;
      d_out     <= '0;
      d_oe      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rw    <= 1'b1;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            rw_q    <= req_rw;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (last) begin
              state <= ACTIVE;
              cs    <= CS_SEL;
              rw    <= req_rw;
              a     <= req_addr;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (last) begin
            state <= ACTIVE;
            cs    <= CS_SEL;
            rw    <= rw_q;
            a     <= addr_q;
          end
        end
        ACTIVE: begin
          if (last) begin
            state     <= IDLE;
            cs        <= CS_IDLE;
            rw        <= 1'b1;
            a         <= '0;
            d_oe      <= 1'b0;
            d_out     <= '0;
            rsp_valid <= 1'b1;
            rsp_rw    <= rw_q;
            rsp_rdata <= rw_q ? d_in : '0;
          end else if (ph == PH_PRE_HIGH && !rw_q) begin
            d_oe  <= 1'b1;
            d_out <= wdata_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_s1 <= 1'b0;
      irq_s2 <= 1'b0;
    end else begin
      irq_s1 <= ~irq_n;
      irq_s2 <= irq_s1;
    end
  end

  assign irq = irq_s2;

  // A bus cycle always opens selected with the data bus released
  assert property (@(posedge clk) disable iff (reset)
                   (state == ACTIVE && start) |-> (cs == CS_SEL && !d_oe));

endmodule

// File: tb/tb_pokey_bus_master.sv
// Randomized self-checking bench for pokey_bus_master (HALF=4), using a
// transaction-level timing model derived from the phase arithmetic.
module tb_pokey_bus_master;
  import pokey_bus_pkg::*;

  localparam int HALF = 4;
  localparam int PER  = 2 * HALF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b1;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_rw;
  logic [7:0] rsp_rdata;
  logic       phi2;
  logic [1:0] cs;
  logic       rw;
  logic [3:0] a;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] d_in = 8'hFF;
  logic       irq_n = 1'b1;
  logic       irq;

  int vectors = 0;
  int fails = 0;
  int nedge;
  logic [7:0] last_rdata = 8'h00;

  pokey_bus_master #(.HALF(HALF)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rw    (rsp_rw),
    .rsp_rdata (rsp_rdata),
    .phi2      (phi2),
    .cs        (cs),
    .rw        (rw),
    .a         (a),
    .d_out     (d_out),
    .d_oe      (d_oe),
    .d_in      (d_in),
    .irq_n     (irq_n),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Edges since reset release; at a negedge, nedge % PER is the current phase
  always @(posedge clk or posedge reset) begin
    if (reset) nedge <= 0;
    else       nedge <= nedge + 1;
  end

  function automatic logic [18:0] pk(input logic [1:0] c, input logic r,
                                     input logic [3:0] aa, input logic oe,
                                     input logic [7:0] dd, input logic rdy,
                                     input logic rv, input logic p2);
    return {c, r, aa, oe, dd, rdy, rv, p2};
  endfunction

  function automatic logic [18:0] dut_vec();
    return pk(cs, rw, a, d_oe, d_out, req_ready, rsp_valid, phi2);
  endfunction

  function automatic logic exp_phi2();
    return (nedge % PER) >= HALF;
  endfunction

  task automatic idle(input int n);
    logic [18:0] exp;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      exp = pk(2'b01, 1'b1, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0, exp_phi2());
      vectors++;
      if (dut_vec() !== exp) begin
        fails++;
        $display("FAIL idle_bus t=%0t got %h exp %h", $time, dut_vec(), exp);
      end
      vectors++;
      if (rsp_rdata !== last_rdata) begin
        fails++;
        $display("FAIL idle_rdata_hold got %h exp %h", rsp_rdata, last_rdata);
      end
    end
  endtask

  task automatic idle_to(input int ph);
    for (int k = 0; k < PER && (nedge % PER) != ph; k++) idle(1);
  endtask

  // Caller is positioned at a negedge with the DUT idle; returns at the response cycle.
  task automatic run_txn(input logic rw_i, input logic [3:0] addr_i,
                         input logic [7:0] wd, input logic [7:0] rd, input bit keep);
    int p;
    int d;
    logic [18:0] exp;
    logic [7:0] exp_rd;
    p = nedge % PER;
    d = PER - p;
    vectors++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_ready got %b exp 1", req_ready);
    end
    req_valid = 1'b1;
    req_rw    = rw_i;
    req_addr  = addr_i;
    req_wdata = wd;
    for (int i = 1; i <= d + PER; i++) begin
      @(negedge clk);
      if (!keep) begin
        req_valid = (i == d + PER) ? 1'b0 : 1'($urandom);
        req_rw    = 1'($urandom);
        req_addr  = 4'($urandom);
        req_wdata = 8'($urandom);
      end
      d_in = (i == d + PER - 1) ? rd : 8'hFF;
      if (i < d)
        exp = pk(2'b01, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, exp_phi2());
      else if (i < d + PER)
        exp = pk(2'b10, rw_i, addr_i, !rw_i && (i - d) >= HALF,
                 (!rw_i && (i - d) >= HALF) ? wd : 8'h00, 1'b0, 1'b0, exp_phi2());
      else
        exp = pk(2'b01, 1'b1, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, exp_phi2());
      vectors++;
      if (dut_vec() !== exp) begin
        fails++;
        $display("FAIL txn_bus p=%0d i=%0d got %h exp %h", p, i, dut_vec(), exp);
      end
      if (i < d + PER) begin
        vectors++;
        if (rsp_rdata !== last_rdata) begin
          fails++;
          $display("FAIL txn_rdata_hold i=%0d got %h exp %h", i, rsp_rdata, last_rdata);
        end
      end
    end
    d_in = 8'hFF;
    exp_rd = rw_i ? rd : 8'h00;
    vectors++;
    if (rsp_rw !== rw_i || rsp_rdata !== exp_rd) begin
      fails++;
      $display("FAIL rsp_data got rw=%b %h exp rw=%b %h", rsp_rw, rsp_rdata, rw_i, exp_rd);
    end
    last_rdata = exp_rd;
  endtask

  task automatic test_reset();
    logic [18:0] exp;
    repeat (3) @(negedge clk);
    exp = pk(2'b01, 1'b1, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (dut_vec() !== exp || rsp_rw !== 1'b1 || rsp_rdata !== 8'h00 || irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_state got %h rsp_rw=%b rdata=%h irq=%b exp %h/1/00/0",
               dut_vec(), rsp_rw, rsp_rdata, irq, exp);
    end
    reset = 1'b0;
    last_rdata = 8'h00;
    idle(2 * PER);
  endtask

  task automatic test_write_audctl();
    idle_to(PER - 1);
    run_txn(1'b0, AUDCTL, 8'h50, 8'hFF, 1'b0);
    idle(2);
  endtask

  task automatic test_read_random();
    idle(int'($urandom_range(0, 7)));
    run_txn(1'b1, RANDOM, 8'h00, 8'h3C, 1'b0);
    idle(1);
  endtask

  task automatic test_accept_ph0();
    idle_to(0);
    run_txn(1'b0, 4'($urandom), 8'($urandom), 8'hFF, 1'b0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    idle(int'($urandom_range(0, 7)));
    run_txn(1'b0, AUDF1, 8'($urandom), 8'hFF, 1'b1);
    run_txn(1'b0, AUDC1, 8'($urandom), 8'hFF, 1'b0);
    idle(1);
  endtask

  task automatic test_random();
    logic r;
    for (int n = 0; n < 20; n++) begin
      idle(int'($urandom_range(0, 9)));
      r = 1'($urandom);
      run_txn(r, 4'($urandom), 8'($urandom), 8'($urandom_range(0, 254)), 1'b0);
    end
    idle(1);
  endtask

  task automatic test_reset_abort();
    int p;
    int d;
    logic [18:0] exp;
    p = nedge % PER;
    d = PER - p;
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = POTGO;
    req_wdata = 8'hA5;
    for (int i = 1; i <= d + 5; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    vectors++;
    if (d_oe !== 1'b1 || cs !== 2'b10) begin
      fails++;
      $display("FAIL abort_pre got cs=%b d_oe=%b exp 10/1", cs, d_oe);
    end
    #1 reset = 1'b1;
    #1;
    exp = pk(2'b01, 1'b1, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (dut_vec() !== exp) begin
      fails++;
      $display("FAIL abort_immediate got %h exp %h", dut_vec(), exp);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL abort_no_rsp got %b exp 0", rsp_valid);
      end
    end
    reset = 1'b0;
    last_rdata = 8'h00;
    idle(3);
    run_txn(1'b0, IRQEN, 8'h3F, 8'hFF, 1'b0);
    idle(1);
  endtask

  task automatic test_irq();
    for (int n = 0; n < 4; n++) begin
      irq_n = 1'b0;
      @(negedge clk);
      vectors++;
      if (irq !== 1'b0) begin
        fails++;
        $display("FAIL irq_rise_early got %b exp 0", irq);
      end
      @(negedge clk);
      vectors++;
      if (irq !== 1'b1) begin
        fails++;
        $display("FAIL irq_rise got %b exp 1", irq);
      end
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
      irq_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (irq !== 1'b1) begin
        fails++;
        $display("FAIL irq_fall_early got %b exp 1", irq);
      end
      @(negedge clk);
      vectors++;
      if (irq !== 1'b0) begin
        fails++;
        $display("FAIL irq_fall got %b exp 0", irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_audctl();
    test_read_random();
    test_accept_ph0();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/pokey_bus_master.md
POKEY_BUS_MASTER -- requirements
Module: pokey_bus_master

Interface
REQ-001 SHALL have parameter HALF, default 4: clk cycles per phi2 half-period; legal range 2..64.
REQ-002 SHALL have a single clock and an asynchronous, active-high reset; every flop SHALL be clocked by clk's rising edge.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-007 req_rw  input  1  1 = read, 0 = write (POKEY rw polarity).
REQ-008 req_addr  input  4  POKEY register address.
REQ-009 req_wdata  input  8  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse, for reads and writes.
REQ-011 rsp_rw  output  1  rw of the completed cycle.
REQ-012 rsp_rdata  output  8  read data; 0x00 after a write.
REQ-013 phi2  output  1  bus clock to POKEY.
REQ-014 cs  output  2  chip select; 2'b10 = selected, 2'b01 = idle.
REQ-015 rw  output  1  bus read/write.
REQ-016 a  output  4  bus address.
REQ-017 d_out  output  8  bus write data.
REQ-018 d_oe  output  1  d_out drive enable.
REQ-019 d_in  input  8  bus read data.
REQ-020 irq_n  input  1  POKEY irq, active-low, asynchronous.
REQ-021 irq  output  1  synchronized irq, active-high.

Function
REQ-022 A free-running phase counter ph SHALL count 0..2*HALF-1 and wrap to 0; phi2 SHALL be registered and equal 1 when ph >= HALF.
REQ-023 The FSM SHALL have three states:
- IDLE: req_ready=1.
- WAIT: request latched, req_ready=0.
- ACTIVE: exactly one phi2 period, req_ready=0.
REQ-024 On acceptance, rw, addr and wdata SHALL be captured and the FSM SHALL enter WAIT.
REQ-025 WAIT SHALL move to ACTIVE on the first cycle with ph==0 strictly after the acceptance cycle; acceptance at ph==2*HALF-1 therefore launches on the next cycle, and acceptance at ph==0 waits a full period.
REQ-026 During ACTIVE, cs=2'b10 and rw and a SHALL be held stable for all 2*HALF cycles.
REQ-027 Outside ACTIVE, cs=2'b01, rw=1, a=0, d_oe=0 and d_out=0.
REQ-028 For a write, d_oe=1 and d_out=wdata SHALL hold for ph in HALF..2*HALF-1 (phi2 high); d_oe SHALL be 0 for all reads.
REQ-029 For a read, d_in SHALL be sampled at ph==2*HALF-1.
REQ-030 On the cycle after the last ACTIVE cycle, rsp_valid SHALL pulse for exactly 1 cycle with rsp_rw and rsp_rdata valid, and the FSM SHALL enter IDLE.
REQ-031 Back-to-back requests SHALL be separated by at least one idle phi2 period: ACTIVE -> IDLE, then accept, then WAIT until the next ph==0.
REQ-032 rsp_rdata SHALL hold its value until the next response.
REQ-033 irq SHALL be the inverse of irq_n after a 2-flop synchronizer, i.e. 2 clk cycles latency.
REQ-034 req_valid deasserted while in WAIT or ACTIVE SHALL have no effect; a captured request always completes.

Reset
REQ-035 reset SHALL immediately force: ph=0, phi2=0, FSM=IDLE, cs=2'b01, rw=1, a=0, d_out=0, d_oe=0, rsp_valid=0, rsp_rw=1, rsp_rdata=0x00, irq sync flops=0 (irq=0).
REQ-036 Reset asserted during WAIT or ACTIVE SHALL abort the cycle with no rsp_valid and bus outputs idle in the same instant.
REQ-037 After reset deasserts, the first ph==0 cycle SHALL be the first clk edge.

Structure
REQ-038 Package pokey_bus_pkg SHALL hold:
- the state enum (IDLE/WAIT/ACTIVE);
- CS_SEL=2'b10 and CS_IDLE=2'b01;
- write register addresses: AUDF1..AUDC4=0x0-0x7, AUDCTL=0x8, STIMER=0x9, SKREST=0xA, POTGO=0xB, SEROUT=0xD, IRQEN=0xE, SKCTL=0xF;
- read register addresses: KBCODE=0x9, RANDOM=0xA, SERIN=0xD, IRQST=0xE, SKSTAT=0xF.
REQ-039 The phase counter and phi2 generation SHALL be the sub-module pokey_phase_gen, with outputs ph, phi2, start (ph==0) and last (ph==2*HALF-1).

Verification (HALF=4)
REQ-040 Write AUDCTL=0x50 accepted at ph==7 -> next cycle cs=10, a=8, rw=0 for 8 cycles; d_oe=1, d_out=0x50 for the last 4 cycles; then rsp_valid 1 cycle with rsp_rw=0 and rsp_rdata=0x00.
REQ-041 Read RANDOM (a=0xA) with d_in=0x3C during the last ACTIVE cycle and 0xFF elsewhere -> rsp_rdata=0x3C, rsp_rw=1, d_oe=0 throughout.
REQ-042 req_valid held high with 2 writes queued -> the two ACTIVE windows are separated by at least one full 8-cycle period with cs=01, and req_ready is 0 from acceptance to completion.
REQ-043 reset asserted at ph==5 of an ACTIVE write -> cs=01, d_oe=0 immediately, no rsp_valid; after release the next request completes normally.
REQ-044 irq_n falls -> irq=1 exactly 2 clk edges later; irq_n rises -> irq=0 2 edges later.
REQ-045 Acceptance at ph==0 -> ACTIVE starts 8 cycles later, not in the same period.
